prog_clk_divider: RTL
=====================

// Module: prog_clk_divider
// PURPOSE
//  Runtime-programmable integer clock divider: successor to the fixed-ratio divider.
//  Divide ratio is loaded through a valid/ready handshake and applied only at a period boundary.
//  Provides glitch-free enable/stop, a registered divided clock and a period-boundary strobe.
//  Feeds per-lane slow clocks (deserializer, CDR update) in the PHY clocking tree.
// PARAMETERS
//  NBW       8   width of divide-ratio bus and counter; max ratio 2**NBW-1
//  NDIV_RST  2   divide ratio loaded at reset; legal range 2..2**NBW-1
// PORTS
//  cki       in   1    input clock; all logic on posedge
//  rstn      in   1    asynchronous active-low reset
//  en        in   1    run request; 1 = divide, 0 = stop at next period end
//  ndiv      in   NBW  requested divide ratio
//  ndiv_vld  in   1    ndiv valid
//  ndiv_rdy  out  1    ratio holding register free
//  cko       out  1    divided clock, registered
//  tick      out  1    1-cycle strobe on last cycle of each period
//  ndiv_cur  out  NBW  ratio currently in force
//  run       out  1    divider active (state != IDLE)
// BEHAVIOUR
//  Reset (async assert, sync release): cntr=0, cko=0, tick=0, ndiv_cur=NDIV_RST,
//   pend_vld=0, ndiv_rdy=1, run=0, state=IDLE.
//  Clamp: any ndiv < 2 is stored as 2. No bypass mode (no combinational clock path).
//  Counter: cntr cycles 0..ndiv_cur-1 in RUN/STOP; wrap to 0 after ndiv_cur-1.
//  cko: registered; in every RUN/STOP cycle, cko == (cntr >= ndiv_cur>>1).
//   Low for floor(N/2) cycles, high for ceil(N/2); period exactly N cki cycles.
//   Rising edge when cntr reaches N>>1; falling edge at wrap to 0. No runt pulses.
//  tick: high exactly while cntr == ndiv_cur-1 in RUN/STOP; 0 in IDLE.
//  Boundary: cycle with cntr == ndiv_cur-1 in RUN/STOP, or any cycle in IDLE.
//  Ratio handshake:
//   ndiv_rdy = !pend_vld. Accept on ndiv_vld & ndiv_rdy -> pend <= clamp(ndiv), pend_vld=1.
//   At the first boundary after the accept cycle: ndiv_cur <= pend, pend_vld <= 0.
//    Accept on a boundary cycle is NOT applied on that edge; it waits for the next boundary.
//   New period with new ratio starts at cntr=0 on the edge after the boundary.
//   In IDLE, a pending ratio is applied on the edge after acceptance.
//   ndiv_vld while ndiv_rdy=0 is ignored (no capture; source must hold).
//  FSM (state 2 bits):
//   IDLE: cntr=0, cko=0. en=1 -> RUN; first RUN cycle cntr=0, cko=0.
//   RUN : count. en=0 -> STOP (count continues uninterrupted).
//   STOP: count; en=1 -> RUN without disturbing cntr/cko.
//         at boundary with en=0 -> IDLE; cntr=0, cko=0 after that edge.
//   en low on the boundary cycle of RUN: go directly to IDLE after that edge.
//  Stopping never truncates a period: the last high phase is always ceil(N/2) cycles.
//  Reset mid-operation: all state returns to reset values immediately; pending ratio dropped.
//  Counter width NBW; no arithmetic overflow as cntr <= ndiv_cur-1 <= 2**NBW-2.
// TESTING
//  1 reset, en=1, no load -> cko period 2 (1 low,1 high), tick every 2nd cycle, ndiv_cur=2.
//  2 load ndiv=5, en=1 -> cko 2 low/3 high, period 5; tick aligned with cntr=4.
//  3 N=4 running, load 7 at cntr=1 -> current period completes at 4, next period 7 (3/4);
//    second ndiv_vld while ndiv_rdy=0 ignored; ndiv_rdy returns 1 after boundary.
//  4 load ndiv=0 and ndiv=1 -> ndiv_cur=2 each time.
//  5 N=6, drop en at cntr=4 -> finishes period (cntr 5, tick), then IDLE, cko=0, run=0;
//    re-raise en during STOP -> continuous periods, no gap.
//  6 N=9 running, assert rstn=0 mid-high phase -> cko=0, tick=0 immediately; after release
//    ndiv_cur=NDIV_RST, ndiv_rdy=1.

Source files
------------

// File: rtl/prog_clk_divider_if.sv
// Ratio load channel for prog_clk_divider.
// Handshake: the source drives ndiv and raises ndiv_vld; a ratio is taken on
// every rising edge where ndiv_vld && ndiv_rdy. While ndiv_rdy is low the
// sink ignores ndiv_vld entirely, so a source that wants its ratio applied
// must hold ndiv_vld/ndiv stable until it sees ndiv_rdy high at an edge.
interface prog_clk_divider_if #(
  parameter int NBW = 8
);
  logic [NBW-1:0] ndiv;
  logic           ndiv_vld;
  logic           ndiv_rdy;

  modport master (output ndiv, output ndiv_vld, input ndiv_rdy);
  modport slave  (input ndiv, input ndiv_vld, output ndiv_rdy);
endinterface

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider.
// A new ratio is parked in a one-entry holding register and only moved into
// force at a period boundary, so every cko period is a whole period of one
// ratio. cko and tick are registered: their next values are computed from the
// next counter/ratio so they line up with the counter in the same cycle.
module prog_clk_divider #(
  parameter int NBW      = 8,
  parameter int NDIV_RST = 2
) (
  input  logic                cki,
  input  logic                rstn,
  input  logic                en,
  prog_clk_divider_if.slave   ndiv_bus,
  output logic                cko,
  output logic                tick,
  output logic [NBW-1:0]      ndiv_cur,
  output logic                run,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [NBW-1:0] cntr, cntr_nxt;
  logic [NBW-1:0] ndiv_cur_nxt;
  logic [NBW-1:0] pend, pend_nxt;
  logic           pend_vld, pend_vld_nxt;
  logic           cko_nxt, tick_nxt;
  logic           bnd, accept, apply;
  logic [NBW-1:0] ndiv_clamped;

  assign ndiv_bus.ndiv_rdy = !pend_vld;
  assign run               = (state != IDLE);
  assign state_dbg         = state;
  assign ndiv_clamped      = (ndiv_bus.ndiv < NBW'(2)) ? NBW'(2) : ndiv_bus.ndiv;

  // Register all divider state; async reset returns to the idle reset ratio.
  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cntr     <= '0;
      cko      <= 1'b0;
      tick     <= 1'b0;
      ndiv_cur <= NBW'(NDIV_RST);
      pend     <= NBW'(NDIV_RST);
      pend_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      cntr     <= cntr_nxt;
      cko      <= cko_nxt;
      tick     <= tick_nxt;
      ndiv_cur <= ndiv_cur_nxt;
      pend     <= pend_nxt;
      pend_vld <= pend_vld_nxt;
    end
  end

  // Next-state, counter, ratio handover and registered-output precompute.
  always_comb begin
    state_nxt    = state;
    cntr_nxt     = cntr;
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    ndiv_cur_nxt = ndiv_cur;
    cko_nxt      = 1'b0;
    tick_nxt     = 1'b0;

    bnd    = (state == IDLE) || (cntr == (ndiv_cur - NBW'(1)));
    accept = ndiv_bus.ndiv_vld && !pend_vld;
    // A ratio accepted this cycle only has pend_vld set after the edge, so it
    // can never be applied on the same edge it was taken.
    apply  = bnd && pend_vld;

    if (apply) begin
      ndiv_cur_nxt = pend;
      pend_vld_nxt = 1'b0;
    end
    if (accept) begin
      pend_nxt     = ndiv_clamped;
      pend_vld_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        cntr_nxt = '0;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        cntr_nxt = bnd ? '0 : cntr + NBW'(1);
        if (!en) state_nxt = bnd ? IDLE : STOP;
      end
      STOP: begin
        cntr_nxt = bnd ? '0 : cntr + NBW'(1);
        if (en)       state_nxt = RUN;
        else if (bnd) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cntr_nxt  = '0;
      end
    endcase

    if (state_nxt != IDLE) begin
      cko_nxt  = (cntr_nxt >= (ndiv_cur_nxt >> 1));
      tick_nxt = (cntr_nxt == (ndiv_cur_nxt - NBW'(1)));
    end
  end

endmodule
